// File: rtl/stall_ctrl.sv
// Central stall/flush controller for the five-stage MIPS pipeline: RAW, mult/div
// and eret interlocks, with exception requests overriding every stall.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        D_eret,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        Req,
  output logic        PC_WE,
  output logic        D_WE,
  output logic        E_flush,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_rs, stall_rt, stall_md, stall_eret, stall;
  logic        md_start_ok;

  // A source stalls only if a producer in E or M will not have its result
  // forwardable by the time this operand is consumed.
  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] ea3, input logic [1:0] etnew,
                                   input logic [4:0] ma3, input logic [1:0] mtnew);
    raw_hit = (src != 5'd0) &&
              (((src == ea3) && (etnew > tuse)) || ((src == ma3) && (mtnew > tuse)));
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_rs   = raw_hit(D_rs, D_rs_tuse, E_A3, E_tnew, M_A3, M_tnew);
    stall_rt   = raw_hit(D_rt, D_rt_tuse, E_A3, E_tnew, M_A3, M_tnew);
    stall_md   = D_md_use && ((md_cnt_q != 4'd0) || E_md_start);
    stall_eret = D_eret && (E_mtc0_epc || M_mtc0_epc);
    stall      = stall_rs || stall_rt || stall_md || stall_eret;
  end

  always_comb begin
    PC_WE   = Req || !stall;
    D_WE    = Req || !stall;
    E_flush = !Req && stall;
  end

  // A start while busy cannot occur in a correct pipeline, so it is simply ignored;
  // Req never aborts a running operation because HI/LO must still complete.
  assign md_start_ok = E_md_start && !Req && (md_cnt_q == 4'd0);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_ok)
      md_cnt_d = E_md_div ? DIV_LD : MULT_LD;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !Req)
      stall_cnt_d = sat_inc32(stall_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_cnt    = md_cnt_q;
  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;

endmodule
